onenot_ctrl: RTL

Sequencer for the `onenot` datapath. It collects nine 16-bit operands (A..I) one word at a time over a valid/ready input stream, then holds them on a parallel operand bus driving an `onenot` instance. After a fixed settle interval it captures the datapath result `y` and presents it, with a per-operand thermometer-code error mask, on a valid/ready output. It sits between a serial producer (bus bridge or test sequencer) and the purely combinational `onenot` block.

---
 rtl/onenot_pkg.sv | 19 +
 rtl/onenot_ctrl_thermo_check.sv | 15 +
 rtl/onenot_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/onenot_pkg.sv
// Shared types and default sizing for the onenot operand sequencer.
package onenot_pkg;

    localparam int WIDTH_DEF   = 16;
    localparam int NUM_OPS_DEF = 9;
    localparam int SETTLE_DEF  = 2;

    // Slot index width for the default operand count; settle counter covers 1..15.
    localparam int IDX_W = $clog2(NUM_OPS_DEF);
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/onenot_ctrl_thermo_check.sv
// Flags whether a word is a thermometer code (2^n-1, including all-zeros and all-ones).
module thermo_check #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] w,
    output logic             legal
);

    logic [WIDTH-1:0] w_inc;

    // All-ones wraps to zero here, so 0xFFFF checks as legal.
    assign w_inc = w + WIDTH'(1);
    assign legal = ~|(w & w_inc);

endmodule

// File: rtl/onenot_ctrl.sv
// Collects NUM_OPS operands serially, holds them on a parallel bus for the onenot
// datapath, then captures its result and a per-operand thermometer error mask.
module onenot_ctrl
    import onenot_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int NUM_OPS = NUM_OPS_DEF,
    parameter int SETTLE  = SETTLE_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic [NUM_OPS*WIDTH-1:0] op_bus,
    output logic                     op_valid,
    input  logic [WIDTH-1:0]         dp_y,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [NUM_OPS-1:0]       out_err
);

    localparam int IW = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;

    state_t                          r_state;
    state_t                          w_next;
    logic [IW-1:0]                   r_idx;
    logic [CNT_W-1:0]                r_cnt;
    logic [NUM_OPS-1:0][WIDTH-1:0]   r_slots;
    logic [NUM_OPS-1:0]              r_mask;
    logic                            w_accept;
    logic                            w_last;
    logic                            w_fire;
    logic                            w_hs;
    logic                            w_legal;

    thermo_check #(.WIDTH(WIDTH)) u_thermo (
        .w     (in_data),
        .legal (w_legal)
    );

    assign w_accept = in_valid & in_ready;
    assign w_last   = w_accept && (r_idx == IW'(NUM_OPS - 1));
    assign w_fire   = (r_state == ST_SETTLE) && (r_cnt == CNT_W'(SETTLE - 1));
    assign w_hs     = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (clear) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   if (w_accept) w_next = w_last ? ST_SETTLE : ST_LOAD;
                ST_LOAD:   if (w_last)   w_next = ST_SETTLE;
                ST_SETTLE: if (w_fire)   w_next = ST_DONE;
                ST_DONE:   if (w_hs)     w_next = ST_IDLE;
                default:                 w_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready = 1'b0;
        op_valid = 1'b0;
        case (r_state)
            ST_IDLE, ST_LOAD:   in_ready = 1'b1;
            ST_SETTLE, ST_DONE: op_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= '0;
            r_cnt <= '0;
        end else if (clear) begin
            r_idx <= '0;
            r_cnt <= '0;
        end else begin
            if (w_accept)
                r_idx <= w_last ? '0 : r_idx + IW'(1);
            else if (w_hs)
                r_idx <= '0;
            if (w_last)
                r_cnt <= '0;
            else if (r_state == ST_SETTLE)
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // A fresh transaction wipes stale mask bits from the previous one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mask <= '0;
        end else if (clear) begin
            r_mask <= '0;
        end else if (w_accept) begin
            for (int k = 0; k < NUM_OPS; k++) begin
                if (r_idx == IW'(k))
                    r_mask[k] <= ~w_legal;
                else if (r_state == ST_IDLE)
                    r_mask[k] <= 1'b0;
            end
        end
    end

    // Slots survive clear; only reset zeroes them.
    for (genvar k = 0; k < NUM_OPS; k++) begin : g_slot
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                r_slots[k] <= '0;
            else if (!clear && w_accept && (r_idx == IW'(k)))
                r_slots[k] <= in_data;
        end
    end

    assign op_bus = r_slots;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= '0;
        end else if (clear) begin
            out_valid <= 1'b0;
        end else if (w_fire) begin
            out_valid <= 1'b1;
            out_data  <= dp_y;
            out_err   <= r_mask;
        end else if (w_hs) begin
            out_valid <= 1'b0;
        end
    end

endmodule
